nand2_arbiter: RTL and testbench

- Round-robin scheduler that shares one external nand2 datapath among N_REQ requesters.
- Each requester presents a request plus an A/B operand pair. The arbiter grants one requester and drives the shared gate's inputs. It waits a settle interval, samples the gate output, then returns the result with a one-cycle done pulse.
- Sits between requester logic (or GPIO stimulus interfaces) and the nand2 instance.

---
 rtl/nand2_arbiter.sv | 162 ++++++++++++++++
 tb/tb_nand2_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand2_arbiter.sv
// ============================================================================
// Module   : nand2_arbiter
// Purpose  : Round-robin scheduler that shares one external nand2 gate among
//            N_REQ requesters. It grants a requester and drives that
//            requester's operands onto the gate. It holds them for
//            SETTLE_CYCLES cycles, samples the gate output, and returns the
//            result with a one-cycle done pulse.
// Option   : define NAND2_ARB_CHECK_EN to add the o_ERR port. o_ERR is a
//            sticky flag that flags a gate output that disagrees with NAND
//            of the driven operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nand2_arbiter #(
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [N_REQ-1:0] i_REQ,
  input  logic [N_REQ-1:0] i_A,
  input  logic [N_REQ-1:0] i_B,
  output logic [N_REQ-1:0] o_GNT,
  output logic [N_REQ-1:0] o_DONE,
  output logic             o_Y,
  output logic             o_BUSY,
  output logic             o_NAND_A,
  output logic             o_NAND_B,
  input  logic             i_NAND_Y
`ifdef NAND2_ARB_CHECK_EN
  ,
  output logic             o_ERR
`endif
);

  localparam int         PW          = $clog2(N_REQ);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       rst_sync;
  logic             run;
  logic [PW-1:0]    ptr;
  logic [3:0]       cnt;
  logic [N_REQ-1:0] cur;

  logic             sel_valid;
  logic [PW-1:0]    sel_idx;
  logic [N_REQ-1:0] sel_onehot;
  logic [PW-1:0]    next_ptr;

  // Two-flop release of the asynchronous reset, so the FSM starts cleanly
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  // Round-robin search: first set request at or above ptr, wrapping around.
  // The loop walks offsets from high to low, so the smallest offset wins.
  always_comb begin : p_select
    int j;
    sel_valid  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    j          = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (i_REQ[j]) begin
        sel_valid     = 1'b1;
        sel_idx       = j[PW-1:0];
        sel_onehot    = '0;
        sel_onehot[j] = 1'b1;
      end
    end
  end

  // Pointer moves to the slot after the winner, so the winner goes to the back
  assign next_ptr = (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + PW'(1);

  // Main FSM: grant, hold operands, sample the gate, then pulse done
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      cur      <= '0;
      o_GNT    <= '0;
      o_DONE   <= '0;
      o_Y      <= 1'b0;
      o_BUSY   <= 1'b0;
      o_NAND_A <= 1'b0;
      o_NAND_B <= 1'b0;
    end else begin
      o_GNT  <= '0;
      o_DONE <= '0;
      case (state)
        ST_IDLE: begin
          if (run && sel_valid) begin
            o_GNT    <= sel_onehot;
            cur      <= sel_onehot;
            o_NAND_A <= i_A[sel_idx];
            o_NAND_B <= i_B[sel_idx];
            cnt      <= SETTLE_LOAD;
            ptr      <= next_ptr;
            o_BUSY   <= 1'b1;
            state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          o_Y      <= i_NAND_Y;
          o_DONE   <= cur;
          o_NAND_A <= 1'b0;
          o_NAND_B <= 1'b0;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          o_BUSY <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_BUSY <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NAND2_ARB_CHECK_EN
  // Sticky flag: the gate output disagrees with NAND of the operands being driven
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      o_ERR <= 1'b0;
    end else if (state == ST_SAMPLE && (i_NAND_Y != ~(o_NAND_A & o_NAND_B))) begin
      o_ERR <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_nand2_arbiter.sv
// ============================================================================
// Module   : tb_nand2_arbiter
// Purpose  : Directed self-checking bench for nand2_arbiter with N_REQ=4 and
//            SETTLE_CYCLES=2. A behavioural nand2 is attached, and its output
//            can be forced to a chosen value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nand2_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       y;
  logic       busy;
  logic       nand_a;
  logic       nand_b;
  logic       nand_y;
  logic       force_en;
  logic       force_val;
`ifdef NAND2_ARB_CHECK_EN
  logic       err;
`endif

  int checks;
  int failures;

  nand2_arbiter #(
    .N_REQ        (4),
    .SETTLE_CYCLES(2)
  ) dut (
    .i_CLK   (clk),
    .i_RST   (rst_n),
    .i_REQ   (req),
    .i_A     (a_in),
    .i_B     (b_in),
    .o_GNT   (gnt),
    .o_DONE  (done),
    .o_Y     (y),
    .o_BUSY  (busy),
    .o_NAND_A(nand_a),
    .o_NAND_B(nand_b),
    .i_NAND_Y(nand_y)
`ifdef NAND2_ARB_CHECK_EN
    ,
    .o_ERR   (err)
`endif
  );

  // Behavioural shared nand2 gate, with an override for fault injection
  assign nand_y = force_en ? force_val : ~(nand_a & nand_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
    force_en = 1'b0; force_val = 1'b0;
    step(); step();
    checks++;
    if ({gnt, done, y, busy, nand_a, nand_b} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected all zero", {gnt, done, y, busy, nand_a, nand_b});
    end
`ifdef NAND2_ARB_CHECK_EN
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    logic [3:0] oh;
    logic       exp_y;
    int         k_tab [4] = '{0, 0, 1, 3};
    logic       a_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       b_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 4; v++) begin
      oh    = 4'b0001 << k_tab[v];
      exp_y = ~(a_tab[v] & b_tab[v]);
      a_in  = a_tab[v] ? oh : 4'b0000;
      b_in  = b_tab[v] ? oh : 4'b0000;
      req   = oh;
      step();
      checks++;
      if (gnt !== oh || busy !== 1'b1 || nand_a !== a_tab[v] || nand_b !== b_tab[v]) begin
        failures++;
        $display("FAIL single_grant[%0d]: gnt=%b busy=%b a=%b b=%b expected gnt=%b busy=1 a=%b b=%b",
                 v, gnt, busy, nand_a, nand_b, oh, a_tab[v], b_tab[v]);
      end
      req = '0;
      step();
      checks++;
      if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_pulse[%0d]: got %b expected 0000", v, gnt); end
      step();
      checks++;
      if (done !== 4'b0000) begin failures++; $display("FAIL single_early_done[%0d]: got %b expected 0000", v, done); end
      step();
      checks++;
      if (done !== oh || y !== exp_y) begin
        failures++;
        $display("FAIL single_done[%0d]: done=%b y=%b expected done=%b y=%b", v, done, y, oh, exp_y);
      end
      step();
      checks++;
      if (done !== 4'b0000 || busy !== 1'b0 || y !== exp_y || nand_a !== 1'b0 || nand_b !== 1'b0) begin
        failures++;
        $display("FAIL single_after[%0d]: done=%b busy=%b y=%b a=%b b=%b expected 0000 0 %b 0 0",
                 v, done, busy, y, nand_a, nand_b, exp_y);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] eg;
    logic [3:0] ed;
    logic [3:0] y_tab;
    // Operand pairs per requester: r0=(0,0) r1=(1,0) r2=(1,1) r3=(0,1)
    a_in  = 4'b0110;
    b_in  = 4'b1100;
    y_tab = 4'b1011;
    req   = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      step();
      eg = 4'b0000;
      ed = 4'b0000;
      if ((c - 1) % 5 == 0) eg = 4'b0001 << (((c - 1) / 5) % 4);
      if (c >= 4 && (c - 4) % 5 == 0) ed = 4'b0001 << (((c - 4) / 5) % 4);
      checks++;
      if (gnt !== eg || done !== ed) begin
        failures++;
        $display("FAIL rr_cycle[%0d]: gnt=%b done=%b expected gnt=%b done=%b", c, gnt, done, eg, ed);
      end
      if (ed != 4'b0000) begin
        checks++;
        if (y !== y_tab[((c - 4) / 5) % 4]) begin
          failures++;
          $display("FAIL rr_y[%0d]: got %b expected %b", c, y, y_tab[((c - 4) / 5) % 4]);
        end
      end
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_operand_change;
    a_in = 4'b0100;
    b_in = 4'b0100;
    req  = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL opchg_grant: got %b expected 0100", gnt); end
    a_in = 4'b0000;
    req  = 4'b0000;
    step();
    checks++;
    if (nand_a !== 1'b1 || nand_b !== 1'b1) begin
      failures++;
      $display("FAIL opchg_hold: a=%b b=%b expected 1 1", nand_a, nand_b);
    end
    step(); step();
    checks++;
    if (done !== 4'b0100 || y !== 1'b0) begin
      failures++;
      $display("FAIL opchg_done: done=%b y=%b expected 0100 0", done, y);
    end
    step(); step();
  endtask

  task automatic test_fairness;
    a_in = '0;
    b_in = '0;
    req  = 4'b0001;
    step();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL fair_first: got %b expected 0001", gnt); end
    step();
    req = 4'b1001;
    step(); step(); step(); step();
    checks++;
    if (gnt !== 4'b1000) begin failures++; $display("FAIL fair_second: got %b expected 1000", gnt); end
    req = 4'b0001;
    for (int n = 0; n < 5; n++) step();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL fair_third: got %b expected 0001", gnt); end
    req = 4'b0000;
    for (int n = 0; n < 4; n++) step();
    checks++;
    if (busy !== 1'b0 || y !== 1'b1) begin
      failures++;
      $display("FAIL fair_idle: busy=%b y=%b expected 0 1", busy, y);
    end
  endtask

  task automatic test_reset_mid;
    int         first;
    logic [3:0] g;
    req = 4'b0010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL rmid_grant: got %b expected 0010", gnt); end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, y, busy, nand_a, nand_b} !== 12'h000) begin
      failures++;
      $display("FAIL rmid_async: got %b expected all zero", {gnt, done, y, busy, nand_a, nand_b});
    end
    for (int n = 0; n < 2; n++) begin
      step();
      checks++;
      if (done !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rmid_hold[%0d]: done=%b busy=%b expected 0000 0", n, done, busy);
      end
    end
    rst_n = 1'b1;
    first = 0;
    g     = '0;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (first == 0 && gnt !== 4'b0000) begin
        first = n;
        g     = gnt;
        req   = 4'b0000;
      end
    end
    checks++;
    if (first < 2 || first > 4) begin
      failures++;
      $display("FAIL rmid_release: first grant at edge %0d expected edge 2..4", first);
    end
    checks++;
    if (g !== 4'b0010) begin failures++; $display("FAIL rmid_regrant: got %b expected 0010", g); end
    req = 4'b0000;
    for (int n = 0; n < 4; n++) step();
  endtask

`ifdef NAND2_ARB_CHECK_EN
  task automatic test_check;
    a_in = 4'b0001; b_in = 4'b0001; req = 4'b0001;
    force_en = 1'b1; force_val = 1'b1;
    step();
    req = 4'b0000;
    step(); step();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL chk_pre: got %b expected 0", err); end
    step();
    checks++;
    if (err !== 1'b1 || y !== 1'b1) begin
      failures++;
      $display("FAIL chk_set: err=%b y=%b expected 1 1", err, y);
    end
    force_en = 1'b0;
    step(); step();
    req = 4'b0001;
    step();
    req = 4'b0000;
    step(); step(); step();
    checks++;
    if (err !== 1'b1 || y !== 1'b0 || done !== 4'b0001) begin
      failures++;
      $display("FAIL chk_sticky: err=%b y=%b done=%b expected 1 0 0001", err, y, done);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL chk_clear: got %b expected 0", err); end
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_operand_change();
    test_fairness();
    test_reset_mid();
`ifdef NAND2_ARB_CHECK_EN
    test_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
